// File: rtl/uart_receiver_if.sv
// Byte stream between the UART receiver and the character writer.
// The receiver is master (drives valid/byte); the consumer is slave (drives ready).
interface uart_receiver_if;
    logic       character_valid;
    logic [7:0] character_byte;
    logic       character_ready;

    modport master (
        output character_valid,
        output character_byte,
        input  character_ready
    );

    modport slave (
        input  character_valid,
        input  character_byte,
        output character_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with a first-word fall-through byte FIFO.
// Bytes appear on the valid/ready stream one clock after their stop-bit sample.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset_low,
    input  logic            rx,
    uart_receiver_if.master chr,
    output logic            overrun,
    output logic            framing_error
);
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    localparam logic [CW-1:0]    HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      sh_q;
    logic            cnt_clr, idx_clr, shift_en, push_c, ferr_c;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic            valid_q;
    logic            pop_c, full_c, wr_en_c, drop_c;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (cnt_q == HALF) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (cnt_q == LAST && idx_q == 3'd7) state_d = S_STOP;
            S_STOP:      if (cnt_q == LAST) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        push_c   = 1'b0;
        ferr_c   = 1'b0;
        case (state_q)
            S_IDLE:      cnt_clr = 1'b1;
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    push_c = rx_s;
                    ferr_c = !rx_s;
                end
            end
            S_WAIT_IDLE: cnt_clr = 1'b1;
            default:     cnt_clr = 1'b1;
        endcase
    end

    // Bit timing and LSB-first deserialiser
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            cnt_q <= '0;
            idx_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + CW'(1);
            if (idx_clr)       idx_q <= '0;
            else if (shift_en) idx_q <= idx_q + 3'd1;
            if (shift_en)      sh_q  <= {rx_s, sh_q[7:1]};
        end
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign pop_c   = valid_q && chr.character_ready;
    assign full_c  = (count_q == FULL);
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    always_comb begin
        count_d = count_q;
        if (wr_en_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (!wr_en_c && pop_c) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr_q] <= sh_q;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q       <= count_d;
            valid_q       <= (count_d != '0);
            overrun       <= drop_c;
            framing_error <= ferr_c;
        end
    end

    assign chr.character_valid = valid_q;
    assign chr.character_byte  = mem[rd_ptr_q];
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frame streams scored against a queue-based model of the byte stream.
module tb_uart_receiver;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    // Posedges from the start-bit drive to the stop-sample edge:
    // 2 sync flops + idle detect, half-bit start check, then 9 full bit periods.
    localparam int STOP_SAMPLE = 3 + CPB / 2 + 1 + 9 * CPB;

    logic clk = 1'b0;
    logic reset_low;
    logic rx;
    logic ready;
    logic overrun;
    logic framing_error;

    uart_receiver_if bus ();
    assign bus.character_ready = ready;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_low    (reset_low),
        .rx           (rx),
        .chr          (bus),
        .overrun      (overrun),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed stream
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         valid_cycles, ov_cnt, fe_cnt, both_cnt;

    // Reference model: FIFO contents and expected consumer-side results
    logic [7:0] mq[$];
    logic [7:0] exp_out[$];
    int         exp_ov, exp_fe;

    always @(negedge clk) begin
        #1;
        if (reset_low) begin
            if (bus.character_valid && ready) begin
                got_q.push_back(bus.character_byte);
                got_cyc.push_back(cyc);
            end
            if (bus.character_valid) valid_cycles++;
            if (overrun) ov_cnt++;
            if (framing_error) fe_cnt++;
            if (overrun && framing_error) both_cnt++;
        end
    end

    task automatic tb_clear();
        got_q.delete();
        got_cyc.delete();
        mq.delete();
        exp_out.delete();
        valid_cycles = 0;
        ov_cnt = 0;
        fe_cnt = 0;
        both_cnt = 0;
        exp_ov = 0;
        exp_fe = 0;
    endtask

    // One frame reaching its stop sample; pop = consumer takes the head that same cycle
    task automatic m_frame(input logic [7:0] b, input bit stop_ok, input bit pop);
        if (!stop_ok) exp_fe++;
        else if (mq.size() == DEPTH) begin
            if (pop) begin
                exp_out.push_back(mq.pop_front());
                mq.push_back(b);
            end else begin
                exp_ov++;
            end
        end else begin
            mq.push_back(b);
        end
    endtask

    task automatic m_drain();
        while (mq.size() != 0) exp_out.push_back(mq.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit pulse_ready,
                              output int start_cyc);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        start_cyc = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (k == 0) start_cyc = cyc;
            rx = bits[k / CPB];
            if (pulse_ready) ready = (k == STOP_SAMPLE - 1);
        end
        if (pulse_ready) begin
            @(negedge clk);
            ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_low = 1'b0;
        rx = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.character_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, want 0", bus.character_valid); end
        checks++; if (bus.character_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h, want 00", bus.character_byte); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, want 0", overrun); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing: got %b, want 0", framing_error); end
        @(negedge clk);
        reset_low = 1'b1;
        idle(2 * CPB);
    endtask

    task automatic test_single();
        int s;
        tb_clear();
        ready = 1'b1;
        send_frame(8'h41, 1'b1, 1'b0, s);
        m_frame(8'h41, 1'b1, 1'b0);
        m_drain();
        idle(CPB);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h41) begin errors++; $display("FAIL single_byte: got %0d bytes (first %h), want 1 byte 41", got_q.size(), got_q.size() ? got_q[0] : 8'h00); end
        checks++; if (got_cyc.size() != 1 || got_cyc[0] != s + STOP_SAMPLE) begin errors++; $display("FAIL single_latency: valid at cycle %0d, want %0d", got_cyc.size() ? got_cyc[0] : -1, s + STOP_SAMPLE); end
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL single_valid_len: got %0d cycles, want 1", valid_cycles); end
        checks++; if (ov_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL single_errors: overrun %0d framing %0d, want 0 0", ov_cnt, fe_cnt); end
    endtask

    task automatic test_back_to_back();
        int s;
        tb_clear();
        ready = 1'b0;
        send_frame(8'h48, 1'b1, 1'b0, s);
        send_frame(8'h69, 1'b1, 1'b0, s);
        m_frame(8'h48, 1'b1, 1'b0);
        m_frame(8'h69, 1'b1, 1'b0);
        idle(CPB);
        @(negedge clk);
        ready = 1'b1;
        idle(DEPTH + 4);
        m_drain();
        #1;
        checks++; if (bus.character_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: valid %b after drain, want 0", bus.character_valid); end
        ready = 1'b0;
        checks++; if (got_q.size() != exp_out.size()) begin errors++; $display("FAIL b2b_count: got %0d bytes, want %0d", got_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_out[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h, want %h", i, got_q[i], exp_out[i]); end
        end
        checks++; if (got_cyc.size() != 2 || got_cyc[1] != got_cyc[0] + 1) begin errors++; $display("FAIL b2b_consecutive: %0d pops, not on consecutive cycles", got_cyc.size()); end
        checks++; if (fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL b2b_errors: overrun %0d framing %0d, want 0 0", ov_cnt, fe_cnt); end
    endtask

    task automatic test_overrun();
        int s;
        tb_clear();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, s);
            m_frame(8'(i), 1'b1, 1'b0);
        end
        idle(CPB);
        @(negedge clk);
        ready = 1'b1;
        idle(DEPTH + 4);
        ready = 1'b0;
        m_drain();
        checks++; if (ov_cnt != exp_ov) begin errors++; $display("FAIL ovr_pulses: got %0d, want %0d", ov_cnt, exp_ov); end
        checks++; if (got_q.size() != exp_out.size()) begin errors++; $display("FAIL ovr_count: got %0d bytes, want %0d", got_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_out[i]) begin errors++; $display("FAIL ovr_byte%0d: got %h, want %h", i, got_q[i], exp_out[i]); end
        end
        checks++; if (both_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL ovr_framing: framing %0d overlap %0d, want 0 0", fe_cnt, both_cnt); end
    endtask

    task automatic test_full_push_pop();
        int s;
        tb_clear();
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, s);
            m_frame(8'(i), 1'b1, 1'b0);
        end
        send_frame(8'h05, 1'b1, 1'b1, s);
        m_frame(8'h05, 1'b1, 1'b1);
        idle(CPB);
        @(negedge clk);
        ready = 1'b1;
        idle(DEPTH + 4);
        ready = 1'b0;
        m_drain();
        checks++; if (ov_cnt != exp_ov) begin errors++; $display("FAIL fullpp_overrun: got %0d, want %0d", ov_cnt, exp_ov); end
        checks++; if (got_q.size() != exp_out.size()) begin errors++; $display("FAIL fullpp_count: got %0d bytes, want %0d", got_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_out[i]) begin errors++; $display("FAIL fullpp_byte%0d: got %h, want %h", i, got_q[i], exp_out[i]); end
        end
    endtask

    task automatic test_glitch_framing();
        int s;
        tb_clear();
        ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(3 * CPB);
        checks++; if (valid_cycles != 0 || fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL glitch: valid %0d framing %0d overrun %0d, want 0 0 0", valid_cycles, fe_cnt, ov_cnt); end
        send_frame(8'h55, 1'b0, 1'b0, s);
        m_frame(8'h55, 1'b0, 1'b0);
        repeat (20 * CPB) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(2 * CPB);
        send_frame(8'h7E, 1'b1, 1'b0, s);
        m_frame(8'h7E, 1'b1, 1'b0);
        m_drain();
        idle(CPB);
        checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL break_pulses: got %0d, want %0d", fe_cnt, exp_fe); end
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_out[0]) begin errors++; $display("FAIL after_break: got %0d bytes (first %h), want 1 byte %h", got_q.size(), got_q.size() ? got_q[0] : 8'h00, exp_out[0]); end
        checks++; if (ov_cnt != 0 || both_cnt != 0) begin errors++; $display("FAIL break_overrun: overrun %0d overlap %0d, want 0 0", ov_cnt, both_cnt); end
    endtask

    task automatic test_reset_midframe();
        int s;
        logic [9:0] bits;
        tb_clear();
        ready = 1'b0;
        send_frame(8'hA1, 1'b1, 1'b0, s);
        send_frame(8'hB2, 1'b1, 1'b0, s);
        bits = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
            @(negedge clk);
            rx = bits[k / CPB];
        end
        #1;
        checks++; if (bus.character_valid !== 1'b1) begin errors++; $display("FAIL midrst_queued: valid %b before reset, want 1", bus.character_valid); end
        reset_low = 1'b0;
        #1;
        checks++; if (bus.character_valid !== 1'b0 || bus.character_byte !== 8'h00) begin errors++; $display("FAIL midrst_outputs: valid %b byte %h, want 0 00", bus.character_valid, bus.character_byte); end
        checks++; if (overrun !== 1'b0 || framing_error !== 1'b0) begin errors++; $display("FAIL midrst_pulses: overrun %b framing %b, want 0 0", overrun, framing_error); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_low = 1'b1;
        idle(2 * CPB);
        tb_clear();
        ready = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, s);
        m_frame(8'h3C, 1'b1, 1'b0);
        m_drain();
        idle(CPB);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_out[0]) begin errors++; $display("FAIL midrst_recover: got %0d bytes (first %h), want 1 byte %h", got_q.size(), got_q.size() ? got_q[0] : 8'h00, exp_out[0]); end
        checks++; if (ov_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL midrst_errors: overrun %0d framing %0d, want 0 0", ov_cnt, fe_cnt); end
    endtask

    task automatic test_random_stream();
        int s;
        logic [7:0] b;
        bit ok;
        tb_clear();
        ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, 1'b0, s);
            m_frame(b, ok, 1'b0);
            m_drain();
            if (!ok) begin
                repeat ($urandom_range(0, 2) * CPB) begin
                    @(negedge clk);
                    rx = 1'b0;
                end
                idle(CPB);
            end
            idle($urandom_range(0, 2) * CPB);
        end
        idle(CPB);
        checks++; if (got_q.size() != exp_out.size()) begin errors++; $display("FAIL rstream_count: got %0d bytes, want %0d", got_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_out[i]) begin errors++; $display("FAIL rstream_byte%0d: got %h, want %h", i, got_q[i], exp_out[i]); end
        end
        checks++; if (fe_cnt != exp_fe || ov_cnt != exp_ov) begin errors++; $display("FAIL rstream_errors: framing %0d overrun %0d, want %0d %0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
    endtask

    task automatic test_random_burst();
        int s;
        int nf;
        logic [7:0] b;
        bit ok;
        tb_clear();
        ready = 1'b0;
        nf = $urandom_range(3, 7);
        for (int n = 0; n < nf; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok, 1'b0, s);
            m_frame(b, ok, 1'b0);
            if (!ok) idle(CPB);
        end
        idle(CPB);
        @(negedge clk);
        ready = 1'b1;
        idle(DEPTH + 4);
        ready = 1'b0;
        m_drain();
        checks++; if (got_q.size() != exp_out.size()) begin errors++; $display("FAIL rburst_count: got %0d bytes, want %0d", got_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_out[i]) begin errors++; $display("FAIL rburst_byte%0d: got %h, want %h", i, got_q[i], exp_out[i]); end
        end
        checks++; if (fe_cnt != exp_fe || ov_cnt != exp_ov) begin errors++; $display("FAIL rburst_errors: framing %0d overrun %0d, want %0d %0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL rburst_overlap: got %0d, want 0", both_cnt); end
    endtask

    initial begin
        tb_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_full_push_pop();
        test_glitch_framing();
        test_reset_midframe();
        test_random_stream();
        test_random_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
